// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V fetch stage with credit-limited imem requests, in-order response pairing,
// a decode-facing instruction buffer and redirect squashing of in-flight work.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7_5
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pcq_q [DEPTH];
  logic [XLEN-1:0] pcq_d [DEPTH];
  logic [AW-1:0]   pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [XLEN-1:0] buf_pc_q [DEPTH];
  logic [XLEN-1:0] buf_pc_d [DEPTH];
  logic [31:0]     buf_data_q [DEPTH];
  logic [31:0]     buf_data_d [DEPTH];
  logic [AW-1:0]   bw_q, bw_d, br_q, br_d;
  logic [CW-1:0]   buf_cnt_q, buf_cnt_d, out_cnt_q, out_cnt_d, drop_q, drop_d;
  logic            acc, rsp, keep, pop;

  always_comb begin
    // credits count both in-flight requests and buffered words, so every response has a slot
    imem_req_valid = !reset && !redirect &&
                     (({1'b0, out_cnt_q} + {1'b0, buf_cnt_q}) < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    acc            = imem_req_valid && imem_req_ready;
    rsp            = imem_rsp_valid && !reset;
    keep           = rsp && drop_q == '0 && !redirect;
    instr_valid    = !reset && !redirect && buf_cnt_q != '0;
    pop            = instr_valid && instr_ready;
    instr          = buf_data_q[br_q];
    instr_pc       = buf_pc_q[br_q];
    opcode         = instr[6:0];
    funct3         = instr[14:12];
    funct7_5       = instr[30];
    fetch_pc_d     = redirect ? (redirect_pc & ~XLEN'(3)) : acc ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    pcq_d          = pcq_q;
    if (acc) pcq_d[pq_wr_q] = fetch_pc_q;
    pq_wr_d        = pq_wr_q + AW'(acc);
    pq_rd_d        = pq_rd_q + AW'(rsp);
    out_cnt_d      = out_cnt_q + CW'(acc) - CW'(rsp);
    drop_d         = redirect ? out_cnt_q - CW'(rsp) :
                     (rsp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    buf_pc_d       = buf_pc_q;
    buf_data_d     = buf_data_q;
    if (keep) begin
      buf_pc_d[bw_q]   = pcq_q[pq_rd_q];
      buf_data_d[bw_q] = imem_rsp_data;
    end
    br_d           = br_q + AW'(pop);
    bw_d           = redirect ? br_q : bw_q + AW'(keep);
    buf_cnt_d      = redirect ? '0 : buf_cnt_q + CW'(keep) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pcq_q      <= '{default: '0};
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
      buf_pc_q   <= '{default: '0};
      buf_data_q <= '{default: '0};
      bw_q       <= '0;
      br_q       <= '0;
      buf_cnt_q  <= '0;
      out_cnt_q  <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pcq_q      <= pcq_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      buf_pc_q   <= buf_pc_d;
      buf_data_q <= buf_data_d;
      bw_q       <= bw_d;
      br_q       <= br_d;
      buf_cnt_q  <= buf_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed phases drive a latency-programmable memory model; a scoreboard
// monitor checks every decode handshake against hand-computed PC sequences.
module tb_fetch_unit;
  logic        clk = 0;
  logic        reset = 1;
  logic        imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect = 0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instr, instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h100), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] due; logic [31:0] addr; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] cyc = '0;
  int          lat = 1;
  int          n_vec = 0, n_err = 0, tot_acc = 0, tot_pop = 0;
  bit          found;

  function automatic logic [31:0] wfun(input logic [31:0] a);
    return {a[15:0], a[15:0]} ^ 32'hC0DE_5033;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  // memory: in-order, latency >= lat, reset together with the DUT
  initial forever begin
    mreq_t m;
    @(negedge clk);
    if (reset) mq.delete();
    else if (imem_req_valid && imem_req_ready) begin
      mq.push_back({cyc + 32'(lat), imem_req_addr});
      acc_log.push_back(imem_req_addr);
      tot_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1;
      imem_rsp_data  = wfun(m.addr);
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = '0;
    end
  end

  // scoreboard monitor
  initial forever begin
    logic [31:0] e, w;
    @(negedge clk);
    if (!reset && instr_valid && instr_ready) begin
      tot_pop++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_instr: got pc %h, required none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        w = wfun(e);
        chk("instr_pc", instr_pc, e);
        chk("instr", instr, w);
        chk("opcode", {25'b0, opcode}, {25'b0, w[6:0]});
        chk("funct3", {29'b0, funct3}, {29'b0, w[14:12]});
        chk("funct7_5", {31'b0, funct7_5}, {31'b0, w[30]});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < bound) begin @(posedge clk); #1; i++; end
    instr_ready = 0;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_acc(input logic [31:0] req, input int bound);
    int n0, i;
    n0 = acc_log.size();
    i = 0;
    while (acc_log.size() == n0 && i < bound) begin @(posedge clk); #1; i++; end
    if (acc_log.size() > n0) chk("next_req_addr", acc_log[n0], req);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL next_req_addr: none within %0d cycles, required %h", bound, req);
    end
  endtask

  initial begin
    tick(3);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    // reset release and streaming
    reset = 0;
    instr_ready = 1;
    push_seq(32'h100, 10);
    @(negedge clk);
    chk("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c0_req_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    chk("c1_instr_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("c2_instr_valid", {31'b0, instr_valid}, 32'd1);
    @(posedge clk); #1;
    drain(60);
    // decode stall: credits cap in-flight plus buffered at DEPTH
    tick(10);
    @(negedge clk);
    chk("stall_inflight", 32'(tot_acc - tot_pop), 32'd2);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
    @(posedge clk); #1;
    push_seq(32'h128, 10);
    instr_ready = 1;
    drain(60);
    // redirect with two 3-cycle requests in flight
    lat = 3;
    redirect = 1; redirect_pc = 32'h1000;
    tick(1);
    redirect = 0;
    tick(2);
    redirect = 1; redirect_pc = 32'h2002;
    tick(1);
    redirect = 0;
    wait_acc(32'h2000, 12);
    push_seq(32'h2000, 6);
    instr_ready = 1;
    drain(80);
    // redirect coinciding with a response and a would-be decode pop
    lat = 1;
    push_seq(32'h2018, 20);
    instr_ready = 1;
    tick(6);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = imem_rsp_valid && imem_req_valid && imem_req_ready;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL rsp_pop_setup: got no response cycle, required one");
    end
    @(posedge clk); #1;
    redirect = 1; redirect_pc = 32'h4001;
    exp_q.delete();
    @(negedge clk);
    chk("rdr_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rdr_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    redirect = 0;
    push_seq(32'h4000, 5);
    @(negedge clk);
    chk("rdr_next_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rdr_next_addr", imem_req_addr, 32'h4000);
    @(posedge clk); #1;
    drain(40);
    // back-to-back redirect suppressing a pending request, then PC wrap
    tick(5);
    redirect = 1; redirect_pc = 32'h8000;
    tick(1);
    redirect = 0;
    tick(1);
    redirect = 1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    chk("wrap_rdr_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("wrap_rdr_instr_valid", {31'b0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    redirect = 0;
    @(negedge clk);
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    push_seq(32'hFFFF_FFF8, 5);
    instr_ready = 1;
    drain(40);
    // reset with a full buffer
    tick(6);
    @(negedge clk);
    chk("full_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("mrst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("mrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst2_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("mrst2_instr", instr, 32'd0);
    chk("mrst2_instr_pc", instr_pc, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    push_seq(32'h100, 3);
    instr_ready = 1;
    @(negedge clk);
    chk("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rel_req_addr", imem_req_addr, 32'h100);
    @(posedge clk); #1;
    drain(40);
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
